// File: rtl/ahb_pkg.sv
// Shared AHB encodings, burst-length decode and arbiter FSM state type.
// Used by ahb_bus_arbiter (optional lock support: AHB_ARB_LOCK_EN).
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Wide enough to hold a 16-beat length.
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_UNDEF = 2'd2
    } arb_state_e;

    // 0 marks an undefined-length (INCR) burst.
    function automatic logic [CNT_W-1:0] burst_len(input logic [2:0] hburst);
        case (hburst[2:1])
            2'b00:   burst_len = hburst[0] ? CNT_W'(0) : CNT_W'(1);
            2'b01:   burst_len = CNT_W'(4);
            2'b10:   burst_len = CNT_W'(8);
            default: burst_len = CNT_W'(16);
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin search: first set req bit after ptr, with wrap.
// 'any' is low when no bit of req is set; idx is then ptr.
module ahb_rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MW-1:0]          ptr,
    output logic [MW-1:0]          idx,
    output logic                   any
);

    int j;

    always_comb begin
        idx = ptr;
        any = 1'b0;
        j   = 0;
        // k == NUM_MASTERS wraps back onto ptr itself, so the owner wins only when alone.
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            j = (int'(ptr) + k) % NUM_MASTERS;
            if (!any && req[j]) begin
                idx = MW'(j);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with burst tracking and bus parking on DEFAULT_MASTER.
// Optional locked-transfer support is built when AHB_ARB_LOCK_EN is defined.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = 2
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
`ifdef AHB_ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0] HLOCK,
`endif
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic                   HRESP,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK,
    output logic [1:0]             dbg_state_o,
    output logic [CNT_W-1:0]       dbg_beat_cnt_o
);

    localparam logic [NUM_MASTERS-1:0] GRANT_ONE = NUM_MASTERS'(1);
    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);

    arb_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, len_q, len_d;
    logic [MW-1:0]          rr_q, gidx_q, master_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic                   mastlock_q;

    logic             beat, nonseq, err2, rearb_ok;
    logic             lock_hold, lock_nxt, pick_any;
    logic [MW-1:0]    pick_idx, winner;
    logic [CNT_W-1:0] cnt_inc, cur_len;

    assign beat    = HREADY && HTRANS[1];
    assign nonseq  = (HTRANS == HTRANS_NONSEQ);
    assign err2    = HRESP && HREADY;
    assign cur_len = burst_len(HBURST);
    assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef AHB_ARB_LOCK_EN
    // mastlock_q stays high for the address phase after HLOCK drops, delaying regrant by one phase.
    assign lock_hold = HLOCK[gidx_q] || mastlock_q;
    assign lock_nxt  = HLOCK[gidx_q];
`else
    assign lock_hold = 1'b0;
    assign lock_nxt  = 1'b0;
`endif

    ahb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW)
    ) u_picker (
        .req (HBUSREQ),
        .ptr (rr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign winner = pick_any ? pick_idx : DEF_IDX;

    // Error response takes priority over beat counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (err2) begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
        end else if (beat && nonseq) begin
            cnt_d = CNT_W'(1);
            len_d = cur_len;
            if (cur_len == '0)
                state_d = ARB_UNDEF;
            else if (cur_len > CNT_W'(1))
                state_d = ARB_BURST;
            else
                state_d = ARB_IDLE;
        end else if (beat) begin
            cnt_d = cnt_inc;
            if (state_q == ARB_BURST && cnt_inc == len_q)
                state_d = ARB_IDLE;
        end else if (HTRANS == HTRANS_IDLE && HREADY) begin
            state_d = ARB_IDLE;
        end
    end

    always_comb begin
        rearb_ok = 1'b0;
        if (state_q == ARB_IDLE && !HTRANS[1] && HREADY)
            rearb_ok = 1'b1;
        if (beat && nonseq && cur_len == CNT_W'(1))
            rearb_ok = 1'b1;
        if (beat && !nonseq && state_q == ARB_BURST && cnt_inc == len_q)
            rearb_ok = 1'b1;
        if (state_q == ARB_UNDEF && !HBUSREQ[master_q])
            rearb_ok = 1'b1;
        if (lock_hold)
            rearb_ok = 1'b0;
        if (err2)
            rearb_ok = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ARB_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            rr_q       <= DEF_IDX;
            gidx_q     <= DEF_IDX;
            grant_q    <= GRANT_ONE << DEFAULT_MASTER;
            master_q   <= DEF_IDX;
            mastlock_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            if (rearb_ok) begin
                gidx_q  <= winner;
                grant_q <= GRANT_ONE << winner;
                if (pick_any)
                    rr_q <= pick_idx;
            end
            if (HREADY) begin
                master_q   <= gidx_q;
                mastlock_q <= lock_nxt;
            end
        end
    end

    assign HGRANT         = grant_q;
    assign HMASTER        = master_q;
    assign HMASTLOCK      = mastlock_q;
    assign dbg_state_o    = state_q;
    assign dbg_beat_cnt_o = cnt_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed scenarios plus randomized traffic against a behavioural arbiter model.
module tb_ahb_bus_arbiter;
    import ahb_pkg::*;

    localparam int N   = 4;
    localparam int DEF = 0;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic       HRESP;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;
    logic [1:0] dbg_state_o;
    logic [4:0] dbg_beat_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: grant/owner indices, burst mode 0=none 1=fixed 2=undefined.
    int m_grant, m_master, m_rr, m_beats, m_left, m_mode;
    bit m_lock;
    int lens[8] = '{1, 0, 4, 4, 8, 8, 16, 16};

    logic [1:0] exp_q[$];

    ahb_bus_arbiter #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (DEF),
        .MW             (2)
    ) dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .HBUSREQ        (HBUSREQ),
`ifdef AHB_ARB_LOCK_EN
        .HLOCK          (HLOCK),
`endif
        .HTRANS         (HTRANS),
        .HBURST         (HBURST),
        .HREADY         (HREADY),
        .HRESP          (HRESP),
        .HGRANT         (HGRANT),
        .HMASTER        (HMASTER),
        .HMASTLOCK      (HMASTLOCK),
        .dbg_state_o    (dbg_state_o),
        .dbg_beat_cnt_o (dbg_beat_cnt_o)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit beat, err2, ns, last, rearb, any;
        int len_now, w, idx;
        if (HRESET) begin
            m_grant = DEF; m_master = DEF; m_rr = DEF;
            m_beats = 0; m_left = 0; m_mode = 0; m_lock = 0;
            return;
        end
        beat    = HREADY && HTRANS[1];
        err2    = HRESP && HREADY;
        ns      = (HTRANS == 2'b10);
        len_now = lens[HBURST];
        last    = beat && (ns ? (len_now == 1) : (m_mode == 1 && m_left == 1));
        rearb   = (m_mode == 0 && !HTRANS[1] && HREADY) || last ||
                  (m_mode == 2 && !HBUSREQ[m_master]);
`ifdef AHB_ARB_LOCK_EN
        if (HLOCK[m_grant] || m_lock) rearb = 0;
`endif
        if (err2) rearb = 1;

        if (err2) begin
            m_mode = 0; m_beats = 0; m_left = 0;
        end else if (beat && ns) begin
            m_beats = 1;
            m_left  = (len_now > 1) ? len_now - 1 : 0;
            m_mode  = (len_now == 0) ? 2 : ((len_now > 1) ? 1 : 0);
        end else if (beat) begin
            m_beats = (m_beats + 1) % 32;
            if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end else if (HTRANS == 2'b00 && HREADY) begin
            m_mode = 0;
        end

        if (HREADY) begin
`ifdef AHB_ARB_LOCK_EN
            m_lock = HLOCK[m_grant];
`endif
            m_master = m_grant;
        end

        if (rearb) begin
            w = DEF; any = 0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_rr + k) % N;
                if (!any && HBUSREQ[idx]) begin
                    w = idx; any = 1;
                end
            end
            m_grant = w;
            if (any) m_rr = w;
        end
    endtask

    task automatic tick();
        logic [1:0] exp_state;
        model_step();
        @(posedge HCLK);
        #1;
        exp_state = (m_mode == 1) ? ARB_BURST : ((m_mode == 2) ? ARB_UNDEF : ARB_IDLE);
        chk("grant",    HGRANT,         32'(4'b0001 << m_grant));
        chk("master",   HMASTER,        32'(m_master));
        chk("mastlock", HMASTLOCK,      32'(m_lock));
        chk("state",    dbg_state_o,    32'(exp_state));
        chk("beat_cnt", dbg_beat_cnt_o, 32'(m_beats));
    endtask

    task automatic drive(input logic [3:0] req, input logic [1:0] tr, input logic [2:0] bu,
                         input logic rdy, input logic rsp);
        HBUSREQ = req; HTRANS = tr; HBURST = bu; HREADY = rdy; HRESP = rsp;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        HLOCK  = 4'b0000;
        drive(4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
        tick();
        tick();
        HRESET = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1; HLOCK = '0;
        drive(4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
        m_grant = DEF; m_master = DEF; m_rr = DEF;
        m_beats = 0; m_left = 0; m_mode = 0; m_lock = 0;

        // Reset and parking
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_grant", HGRANT, 32'(4'b0001));
            chk("t1_master", HMASTER, 32'(0));
            chk("t1_lock", HMASTLOCK, 32'(0));
        end

        // Single requester
        drive(4'b0100, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
        tick();
        chk("t2_grant", HGRANT, 32'(4'b0100));
        chk("t2_master_early", HMASTER, 32'(0));
        tick();
        chk("t2_master", HMASTER, 32'(2));

        // Full load rotation with SINGLE beats
        do_reset();
        exp_q = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        drive(4'b1111, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0);
        tick();
        while (exp_q.size() > 0) begin
            tick();
            chk("t3_owner", HMASTER, 32'(exp_q.pop_front()));
        end

        // INCR4 by M1 with wait states; M3 waiting
        do_reset();
        drive(4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
        tick();
        tick();
        chk("t4_owner", HMASTER, 32'(1));
        drive(4'b1010, HTRANS_NONSEQ, HBURST_INCR4, 1'b1, 1'b0);
        tick();
        chk("t4_grant_b1", HGRANT, 32'(4'b0010));
        drive(4'b1010, HTRANS_SEQ, HBURST_INCR4, 1'b0, 1'b0);
        tick();
        tick();
        chk("t4_grant_wait", HGRANT, 32'(4'b0010));
        chk("t4_master_frozen", HMASTER, 32'(1));
        HREADY = 1'b1;
        tick();
        tick();
        chk("t4_grant_b3", HGRANT, 32'(4'b0010));
        chk("t4_cnt_b3", dbg_beat_cnt_o, 32'(3));
        tick();
        chk("t4_grant_b4", HGRANT, 32'(4'b1000));
        chk("t4_state_b4", dbg_state_o, 32'(ARB_IDLE));

        // INCR8 by M0 aborted by a two-cycle ERROR; M2 waiting
        do_reset();
        drive(4'b0101, HTRANS_NONSEQ, HBURST_INCR8, 1'b1, 1'b0);
        tick();
        drive(4'b0101, HTRANS_SEQ, HBURST_INCR8, 1'b1, 1'b0);
        tick();
        chk("t5_cnt_b2", dbg_beat_cnt_o, 32'(2));
        drive(4'b0101, HTRANS_SEQ, HBURST_INCR8, 1'b0, 1'b1);
        tick();
        chk("t5_grant_err1", HGRANT, 32'(4'b0001));
        HREADY = 1'b1;
        tick();
        chk("t5_grant_err2", HGRANT, 32'(4'b0100));
        chk("t5_cnt_err2", dbg_beat_cnt_o, 32'(0));
        chk("t5_state_err2", dbg_state_o, 32'(ARB_IDLE));

`ifdef AHB_ARB_LOCK_EN
        // Locked SINGLE sequence by M0 with M1 contending
        do_reset();
        HLOCK = 4'b0001;
        drive(4'b0011, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_grant_locked", HGRANT, 32'(4'b0001));
            chk("t6_mastlock", HMASTLOCK, 32'(1));
        end
        HLOCK = 4'b0000;
        tick();
        chk("t6_grant_tail", HGRANT, 32'(4'b0001));
        chk("t6_mastlock_tail", HMASTLOCK, 32'(0));
        tick();
        chk("t6_grant_after", HGRANT, 32'(4'b0010));
        chk("t6_mastlock_after", HMASTLOCK, 32'(0));
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            HRESET  = ($urandom_range(0, 99) == 0);
            HBUSREQ = 4'($urandom_range(0, 15));
            HTRANS  = 2'($urandom_range(0, 3));
            HBURST  = 3'($urandom_range(0, 7));
            HREADY  = ($urandom_range(0, 3) != 0);
            HRESP   = ($urandom_range(0, 19) == 0);
            HLOCK   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
